// File: rtl/instr_encoder_pkg.sv
// Shared format codes, FIFO entry layout and range helpers for the RV32I instruction encoder.
package instr_encoder_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } fifo_entry_t;

  // True when v, read as signed, is representable in w signed bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field/immediate packer: produces the raw instruction word and its legality.
import instr_encoder_pkg::*;

module instr_encoder_imm_pack (
  input  logic [2:0]  typ,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    instr      = '0;
    legal      = 1'b0;
    instr[6:0] = opcode;
    case (typ)
      FMT_R: begin
        instr[11:7]  = rd;
        instr[14:12] = funct3;
        instr[19:15] = rs1;
        instr[24:20] = rs2;
        instr[31:25] = funct7;
        legal        = 1'b1;
      end
      FMT_I: begin
        instr[11:7]  = rd;
        instr[14:12] = funct3;
        instr[19:15] = rs1;
        if (is_shift) begin
          instr[31:25] = funct7;
          instr[24:20] = imm[4:0];
          legal        = (imm[31:5] == '0);
        end else begin
          instr[31:20] = imm[11:0];
          legal        = fits_signed(imm, 12);
        end
      end
      FMT_S: begin
        instr[11:7]  = imm[4:0];
        instr[14:12] = funct3;
        instr[19:15] = rs1;
        instr[24:20] = rs2;
        instr[31:25] = imm[11:5];
        legal        = fits_signed(imm, 12);
      end
      FMT_B: begin
        instr[7]     = imm[11];
        instr[11:8]  = imm[4:1];
        instr[14:12] = funct3;
        instr[19:15] = rs1;
        instr[24:20] = rs2;
        instr[30:25] = imm[10:5];
        instr[31]    = imm[12];
        legal        = fits_signed(imm, 13) && !imm[0];
      end
      FMT_U: begin
        instr[11:7]  = rd;
        instr[31:12] = imm[31:12];
        legal        = (imm[11:0] == '0);
      end
      FMT_J: begin
        instr[11:7]  = rd;
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        instr[31]    = imm[20];
        legal        = fits_signed(imm, 21) && !imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields, queues results in a 2-entry FIFO, counts outcomes.
import instr_encoder_pkg::*;

module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  input  logic        clr_cnt,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  logic [31:0] packed_instr;
  logic        packed_legal;
  fifo_entry_t push_entry;
  fifo_entry_t fifo_mem [2];
  logic        rd_ptr_reg, wr_ptr_reg;
  logic [1:0]  count_reg, count_next;
  logic        in_ready_reg;
  logic [15:0] cnt_ok_reg, cnt_err_reg;
  logic        push, pop;

  instr_encoder_imm_pack u_pack (
    .typ    (in_type),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (packed_instr),
    .legal  (packed_legal)
  );

  // Illegal requests are still queued, replaced by a NOP and flagged.
  assign push_entry.err   = !packed_legal;
  assign push_entry.instr = packed_legal ? packed_instr : NOP_INSTR;

  assign push       = in_valid && in_ready_reg;
  assign pop        = out_valid && out_ready;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  assign in_ready  = in_ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_instr = fifo_mem[rd_ptr_reg].instr;
  assign out_err   = fifo_mem[rd_ptr_reg].err;
  assign cnt_ok    = cnt_ok_reg;
  assign cnt_err   = cnt_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      in_ready_reg <= 1'b1;
      cnt_ok_reg   <= '0;
      cnt_err_reg  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= push_entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg    <= count_next;
      in_ready_reg <= (count_next < 2'd2);
      // A clear in the same cycle as an accept swallows that accept's count.
      if (clr_cnt) begin
        cnt_ok_reg  <= '0;
        cnt_err_reg <= '0;
      end else if (push) begin
        if (packed_legal && cnt_ok_reg != 16'hFFFF) cnt_ok_reg <= cnt_ok_reg + 16'd1;
        if (!packed_legal && cnt_err_reg != 16'hFFFF) cnt_err_reg <= cnt_err_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed encodings.
import instr_encoder_pkg::*;

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        clr_cnt;
  logic [15:0] cnt_ok, cnt_err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ok   = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Single accept with out_ready high; checks the head one cycle later, then lets it drain.
  task automatic one_shot(input string tag, input logic [31:0] exp_instr, input logic exp_e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (exp_e) exp_err++; else exp_ok++;
    $display("txn %s: instr=%h err=%b cnt_ok=%0d cnt_err=%0d", tag, out_instr, out_err, cnt_ok, cnt_err);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".instr"}, out_instr, exp_instr);
    check({tag, ".err"}, {31'd0, out_err}, {31'd0, exp_e});
    check({tag, ".cnt_ok"}, {16'd0, cnt_ok}, exp_ok);
    check({tag, ".cnt_err"}, {16'd0, cnt_err}, exp_err);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    set_req(FMT_I, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_instr", out_instr, 32'd0);
    check("rst.out_err", {31'd0, out_err}, 32'd0);
    check("rst.cnt_ok", {16'd0, cnt_ok}, 32'd0);
    check("rst.cnt_err", {16'd0, cnt_err}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    set_req(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF);
    one_shot("addi", 32'hFFF0_0093, 1'b0);
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3);
    one_shot("srai3", 32'h4031_5113, 1'b0);
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd32);
    one_shot("srai32", NOP_INSTR, 1'b1);
    set_req(FMT_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC);
    one_shot("beq-4", 32'hFE00_0EE3, 1'b0);
    set_req(FMT_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);
    one_shot("beq3", NOP_INSTR, 1'b1);
    set_req(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    one_shot("jal", 32'h0010_00EF, 1'b0);
    set_req(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    one_shot("lui", 32'h1234_52B7, 1'b0);
    set_req(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    one_shot("lui_bad", NOP_INSTR, 1'b1);
    set_req(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFF_FFF8);
    one_shot("sw", 32'hFE51_2C23, 1'b0);
    set_req(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd2048);
    one_shot("sw_bad", NOP_INSTR, 1'b1);
    set_req(FMT_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'd0);
    one_shot("sub", 32'h4020_81B3, 1'b0);
    set_req(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    one_shot("badtype", NOP_INSTR, 1'b1);

    // Backpressure: A and B fill the FIFO, C must wait until the consumer drains.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);  // A = 00100093
    tick();
    check("bp.ready_after_a", {31'd0, in_ready}, 32'd1);
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);  // B = 00200113
    tick();
    check("bp.ready_after_b", {31'd0, in_ready}, 32'd0);
    check("bp.head_a", out_instr, 32'h0010_0093);
    set_req(FMT_I, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);  // C = 00300193
    tick();
    check("bp.c_held", {31'd0, in_ready}, 32'd0);
    check("bp.head_stable", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    tick();
    $display("txn drain1: instr=%h", out_instr);
    check("bp.head_b", out_instr, 32'h0020_0113);
    check("bp.ready_again", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("txn drain2: instr=%h", out_instr);
    check("bp.head_c", out_instr, 32'h0030_0193);
    check("bp.valid_c", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp.empty", {31'd0, out_valid}, 32'd0);
    exp_ok += 3;
    check("bp.cnt_ok", {16'd0, cnt_ok}, exp_ok);

    // Saturation under full throughput.
    set_req(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    in_valid = 1'b1;
    begin
      int stalls = 0;
      for (int i = 0; i < 70000; i++) begin
        if (!in_ready) stalls++;
        tick();
      end
      check("sat.stalls", stalls, 32'd0);
    end
    in_valid = 1'b0;
    $display("txn saturate: cnt_ok=%h cnt_err=%0d", cnt_ok, cnt_err);
    check("sat.cnt_ok", {16'd0, cnt_ok}, 32'h0000_FFFF);
    check("sat.cnt_err", {16'd0, cnt_err}, exp_err);
    tick();

    // Clear coincident with an accept: clear wins, word still queued.
    clr_cnt  = 1'b1;
    in_valid = 1'b1;
    tick();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    $display("txn clr: cnt_ok=%0d cnt_err=%0d", cnt_ok, cnt_err);
    check("clr.cnt_ok", {16'd0, cnt_ok}, 32'd0);
    check("clr.cnt_err", {16'd0, cnt_err}, 32'd0);
    check("clr.pushed", out_instr, 32'h0050_0093);
    tick();

    // Reset mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    $display("txn midrst: out_valid=%b in_ready=%b", out_valid, in_ready);
    check("midrst.no_accept", {31'd0, out_valid}, 32'd0);
    check("midrst.cnt_ok", {16'd0, cnt_ok}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
